// File: rtl/mem_access_unit.sv
// Memory access unit: sequences RV32 loads/stores onto a synchronous SRAM.
// Optional MAU_FAULT_CHECK_EN rejects misaligned, out-of-range and illegal-funct3 accesses.
module mem_access_unit #(
  parameter int WORD_W       = 32,
  parameter int SRAM_ADDR_W  = 11,
  parameter int READ_LATENCY = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_W-1:0]      req_addr,
  input  logic [WORD_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [WORD_W-1:0]      rsp_rdata,
  output logic                   rsp_fault,
  output logic                   sram_en,
  output logic [WORD_W/8-1:0]    sram_we,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0]      sram_wdata,
  input  logic [WORD_W-1:0]      sram_rdata
);

  localparam int BYTES = WORD_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

`ifdef MAU_FAULT_CHECK_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [BYTES-1:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
    logic [BYTES-1:0] be;
    case (size)
      SZ_B:    be = BYTES'(1) << off;
      SZ_H:    be = off[1] ? BYTES'(4'b1100) : BYTES'(4'b0011);
      default: be = '1;
    endcase
    return be;
  endfunction

  function automatic logic [WORD_W-1:0] store_data(input logic [1:0] size, input logic [WORD_W-1:0] wd);
    case (size)
      SZ_B:    return {BYTES{wd[7:0]}};
      SZ_H:    return {(BYTES/2){wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Lane select then sign/zero extension; signed locals make the extension explicit.
  function automatic logic [WORD_W-1:0] load_extract(input logic [1:0] size, input logic uns,
                                                     input logic [1:0] off, input logic [WORD_W-1:0] rd);
    logic [WORD_W-1:0]        lane;
    logic signed [7:0]        b_s;
    logic signed [15:0]       h_s;
    logic signed [WORD_W-1:0] ext;
    lane = rd >> {off, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    if (size == SZ_B) begin
      if (uns) ext = $signed(WORD_W'(lane[7:0]));
      else     ext = WORD_W'(b_s);
    end else if (size == SZ_H) begin
      if (uns) ext = $signed(WORD_W'(lane[15:0]));
      else     ext = WORD_W'(h_s);
    end else begin
      ext = $signed(rd);
    end
    return $unsigned(ext);
  endfunction

  logic [1:0] state;
  logic [1:0] lat_cnt;
  logic       hs;
  logic       d_illegal, d_upper, d_fault, d_uns;
  logic [1:0] d_size, d_off;

  logic       we_p1, fault_p1, uns_p1;
  logic [1:0] size_p1, off_p1;

  assign req_ready = (state == S_IDLE);
  assign hs        = req_valid && req_ready;

  // Illegal funct3 degrades to a word access; misaligned H/W are forced onto their natural lane.
  always_comb begin
    d_illegal = illegal_f3(req_we, req_funct3);
    d_size    = d_illegal ? SZ_W : req_funct3[1:0];
    d_uns     = !req_we && req_funct3[2] && !d_illegal;
    case (d_size)
      SZ_B:    d_off = req_addr[1:0];
      SZ_H:    d_off = {req_addr[1], 1'b0};
      default: d_off = 2'b00;
    endcase
    d_upper = (req_addr >> (SRAM_ADDR_W + 2)) != '0;
    d_fault = FAULT_EN && (d_illegal || d_upper ||
                           ((d_size == SZ_H) && req_addr[0]) ||
                           ((d_size == SZ_W) && (req_addr[1:0] != 2'b00)));
  end

  // Request capture: handshake -> ISSUE stage
  always_ff @(posedge CLK) begin
    if (hs) begin
      we_p1    <= req_we;
      fault_p1 <= d_fault;
      uns_p1   <= d_uns;
      size_p1  <= d_size;
      off_p1   <= d_off;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= S_IDLE;
      lat_cnt    <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            state      <= S_ISSUE;
            sram_en    <= !d_fault;
            sram_we    <= (req_we && !d_fault) ? store_lanes(d_size, d_off) : '0;
            sram_addr  <= req_addr[SRAM_ADDR_W+1:2];
            sram_wdata <= store_data(d_size, req_wdata);
          end
        end
        S_ISSUE: begin
          sram_en <= 1'b0;
          sram_we <= '0;
          if (we_p1 || fault_p1) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_fault <= fault_p1;
          end else begin
            state   <= S_WAIT;
            lat_cnt <= 2'd0;
          end
        end
        // WAIT stage: read data lands in the last counted cycle
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state     <= S_RESP;
            lat_cnt   <= 2'd0;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_extract(size_p1, uns_p1, off_p1, sram_rdata);
            rsp_fault <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width in bits; must be a multiple of 8 and a power of two, minimum 32.
REQ-002 SHALL have parameter SRAM_ADDR_W, default 11, SRAM word-address width; 2048 words by default.
REQ-003 SHALL have parameter READ_LATENCY, default 2, the SRAM read latency in cycles; legal range 1..4.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: the request is valid.
REQ-007 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-008 SHALL have port req_we, input, 1 bit: 1 for a store, 0 for a load.
REQ-009 SHALL have port req_funct3, input, 3 bits: RV32 load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-010 SHALL have port req_addr, input, WORD_W bits: byte address.
REQ-011 SHALL have port req_wdata, input, WORD_W bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, WORD_W bits: load result, extended per funct3.
REQ-014 SHALL have port rsp_fault, output, 1 bit: the access was rejected; qualified by rsp_valid.
REQ-015 SHALL have port sram_en, output, 1 bit: SRAM access strobe.
REQ-016 SHALL have port sram_we, output, WORD_W/8 bits: per-byte write enables.
REQ-017 SHALL have port sram_addr, output, SRAM_ADDR_W bits: word address, equal to req_addr[SRAM_ADDR_W+1:2].
REQ-018 SHALL have port sram_wdata, output, WORD_W bits: lane-positioned store data.
REQ-019 SHALL have port sram_rdata, input, WORD_W bits: SRAM read data.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 A handshake (req_valid && req_ready) in cycle T SHALL register the request and move the FSM to ISSUE at cycle T+1.
REQ-022 In ISSUE, sram_en SHALL be 1 for exactly one cycle unless the request faults; for stores sram_we SHALL hold the byte enables, and for loads sram_we SHALL be 0.
REQ-023 Store byte enables: SB SHALL give a one-hot enable at lane addr[1:0] with the byte replicated across all lanes; SH SHALL give 0011 or 1100 with the halfword replicated; SW SHALL give 1111.
REQ-024 Transitions: ISSUE SHALL go to RESP for stores and faults, and to WAIT for loads; WAIT SHALL count READ_LATENCY cycles, capture sram_rdata in the last one, then go to RESP.
REQ-025 RESP SHALL assert rsp_valid for one cycle, then return to IDLE; there is no response backpressure.
REQ-026 Latency from the handshake cycle T: stores and faults SHALL respond at T+2; loads SHALL respond at T+2+READ_LATENCY; maximum throughput is one request per RESP+1 cycles.
REQ-027 Load extraction: the lane SHALL be selected by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-028 rsp_rdata SHALL be 0 for stores and faults, and SHALL hold its value outside rsp_valid.
REQ-029 req_valid while not ready SHALL be ignored; request inputs are sampled only at the handshake.

Reset
REQ-030 nRST low SHALL immediately force the FSM to IDLE and clear all registered outputs (rsp_valid, rsp_rdata, rsp_fault, sram_en, sram_we, sram_addr, sram_wdata) and the latency counter to 0.
REQ-031 Reset in the middle of an operation SHALL abandon that access, with no rsp_valid; req_ready SHALL read 1 in the first cycle after release.

Configuration
REQ-032 Macro MAU_FAULT_CHECK_EN, when defined, SHALL fault (no SRAM strobe, rsp_fault=1 at RESP) on:
- misalignment: H forms with addr[0]=1, or W forms with addr[1:0]≠0;
- address bits above SRAM_ADDR_W+1 being nonzero;
- illegal funct3: load 011/110/111, or store 1xx/011.
REQ-033 Without MAU_FAULT_CHECK_EN:
- rsp_fault SHALL be tied 0;
- misaligned H/W accesses SHALL be forced aligned (addr low bits treated as 0);
- upper address bits SHALL be ignored;
- illegal funct3 SHALL behave as W.

Verification
REQ-034 SW to addr 0x10 with wdata 0xDEADBEEF -> sram_en=1, sram_we=1111, sram_addr=4 at T+1; rsp_valid at T+2 with fault=0.
REQ-035 SRAM word 4=0x80F1_7F02, READ_LATENCY=2: LB at 0x13 -> rsp_rdata=0xFFFFFF80 at T+4; LBU at 0x13 -> 0x00000080; LH at 0x10 -> 0x00007F02.
REQ-036 SB to 0x11 with wdata 0x000000AB -> sram_we=0010, sram_wdata=0xABABABAB.
REQ-037 With MAU_FAULT_CHECK_EN, LW at 0x12 -> sram_en stays 0, rsp_valid at T+2 with fault=1 and rdata=0; without the macro -> word at 0x10 is returned, fault=0.
REQ-038 nRST pulled low in the WAIT state of a load -> no rsp_valid; req_ready=1 after release; a following SW completes normally.
REQ-039 Continuous req_valid with READ_LATENCY=1..4 -> req_ready=0 outside IDLE, and every accepted request yields exactly one rsp_valid.
